vector_register_file: RTL and testbench
=======================================

// Module: vector_register_file
// PURPOSE
//  Per-core register file for all THREADS lanes of a compute core: NUM_REGS x DATA_W per lane.
//  - Top 3 addresses are read-only specials: %blockIdx, %blockDim, %threadIdx.
//  - Operands are registered in REQUEST; results are written back in UPDATE, masked per lane.
//  - A load scoreboard flags read-after-load hazards to the core scheduler.
//  - Sits between the decoder/scheduler and the per-lane ALU/LSU.
// PARAMETERS
//  THREADS   4   lanes per core (>=1)
//  DATA_W    8   register width in bits
//  NUM_REGS  16  registers per lane; R[NUM_REGS-3..NUM_REGS-1] are special (NUM_REGS>=4)
//  ADDR_W    localparam = $clog2(NUM_REGS)
// PORTS
//  clk               in   1                 core clock
//  reset             in   1                 async, active-high
//  enable            in   1                 core/block active; low = freeze all state
//  core_state        in   3                 scheduler state (gpu_core_pkg encoding)
//  thread_mask       in   THREADS           lane active bits; bit i = lane i
//  rd_addr           in   ADDR_W            destination register
//  rs_addr, rt_addr  in   ADDR_W            source registers
//  reg_write_enable  in   1                 instruction writes rd
//  reg_input_mux     in   2                 00 ALU, 01 MEM, 10 CONST, 11 reserved
//  alu_out           in   THREADS*DATA_W    per-lane ALU results; lane i at [i*DATA_W +: DATA_W]
//  lsu_out           in   THREADS*DATA_W    per-lane load data
//  immediate         in   DATA_W            CONST source (shared by all lanes)
//  block_id          in   DATA_W            value of %blockIdx
//  threads_per_block in   DATA_W            value of %blockDim
//  thread_base       in   DATA_W            %threadIdx of lane 0
//  rs_data, rt_data  out  THREADS*DATA_W    registered operands
//  hazard            out  1                 rs or rt has a pending load
// BEHAVIOUR
//  - Reset (async): all GPRs, rs_data, rt_data, pending bits and hazard -> 0.
//  - enable=0: no writes, no captures; outputs and pending bits hold.
//  - Read (enable & core_state==REQUEST), per lane i, at the clock edge:
//    - rs_data[i] <= R_i[rs_addr]; rt_data[i] <= R_i[rt_addr].
//    - Valid from the next cycle; held until the next REQUEST. Latency 1.
//    - Captured for masked lanes too.
//    - Specials: R[N-3]=block_id, R[N-2]=threads_per_block,
//      R[N-1]=(thread_base+i) mod 2^DATA_W.
//  - hazard (registered alongside the read): pending[rs_addr] | pending[rt_addr].
//    Specials are never pending.
//  - Write (enable & core_state==UPDATE & reg_write_enable & rd_addr<NUM_REGS-3):
//    - Lane i writes R_i[rd_addr] only if thread_mask[i].
//    - Source by mux: ALU->alu_out[i], MEM->lsu_out[i], CONST->immediate.
//    - mux=11: no write, no error.
//  - Writes to special addresses are silently dropped.
//  - Pending bit per GPR address, shared by all lanes:
//    - Set in REQUEST when reg_write_enable & mux==MEM & rd is a GPR.
//    - Cleared in UPDATE when that load writes back.
//    - Set and clear never coincide: REQUEST and UPDATE are different states.
//  - Other core_state values (IDLE, FETCH, DECODE, WAIT, EXECUTE, DONE): no state change.
//  - Reset mid-operation clears pending bits and hazard immediately (async).
//  - Widths: no arithmetic except thread_base+i, which wraps modulo 2^DATA_W.
// STRUCTURE
//  - gpu_core_pkg (shared):
//    - core_state encodings: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5,
//      UPDATE=6, DONE=7.
//    - REG_MUX_ALU/MEM/CONST; special-register offsets.
//  - Sub-module lane_reg_bank, one per lane via generate: GPR storage plus the two
//    registered read ports.
//  - Top level owns the special-register mux, the scoreboard and the lane mask.
// TESTING
//  - Reset then REQUEST rs=1, rt=2 -> rs_data=rt_data=0 in all lanes; hazard=0.
//  - UPDATE, rd=1, mux=CONST, imm=0xDE, mask=4'b1011; then REQUEST rs=1
//    -> lanes 0,1,3 read 0xDE; lane 2 reads 0.
//  - block_id=1, tpb=4, thread_base=0xFE; REQUEST rs=13, rt=15
//    -> rs=0x01 in all lanes; rt lanes = FE, FF, 00, 01.
//  - UPDATE, rd=14, mux=ALU, alu_out=0x55 -> next REQUEST rs=14 still returns 0x04.
//  - REQUEST load rd=5 (mux=MEM), then REQUEST rs=5 -> hazard=1.
//    After UPDATE with lsu_out=0x3C: REQUEST rs=5 -> hazard=0, rs=0x3C.
//  - Set pending on R5, assert reset mid-WAIT -> hazard=0 and all GPRs 0; enable=0 in UPDATE
//    -> no write.

Source files
------------

// File: rtl/gpu_core_pkg.sv
// ============================================================================
// gpu_core_pkg : core scheduler state and register-input mux encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package gpu_core_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_e;

  typedef enum logic [1:0] {
    REG_MUX_ALU   = 2'b00,
    REG_MUX_MEM   = 2'b01,
    REG_MUX_CONST = 2'b10,
    REG_MUX_RSVD  = 2'b11
  } reg_mux_e;

  // Special registers, as distance below NUM_REGS
  localparam int SPECIAL_COUNT      = 3;
  localparam int SPEC_OFS_BLOCK_IDX = 3;
  localparam int SPEC_OFS_BLOCK_DIM = 2;
  localparam int SPEC_OFS_THREAD_ID = 1;

endpackage

`default_nettype wire

// File: rtl/lane_reg_bank.sv
// ============================================================================
// lane_reg_bank : one lane's GPR storage with two registered read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_reg_bank #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cap_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_special,
  input  logic [DATA_W-1:0] rs_special_val,
  input  logic              rt_special,
  input  logic [DATA_W-1:0] rt_special_val,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  // Special slots exist in the array but are never written, so they stay zero
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d;

  always_comb begin
    regs_d = regs_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
    if (cap_en) begin
      rs_d = rs_special ? rs_special_val : regs_q[rs_addr];
      rt_d = rt_special ? rt_special_val : regs_q[rt_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      regs_q <= regs_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end

  assign rs_data = rs_q;
  assign rt_data = rt_q;

endmodule

`default_nettype wire

// File: rtl/vector_register_file.sv
// ============================================================================
// vector_register_file : per-core multi-lane register file with specials,
//                        masked write-back and load scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_register_file
  import gpu_core_pkg::*;
#(
  parameter int THREADS  = 4,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [2:0]                core_state,
  input  logic [THREADS-1:0]        thread_mask,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [ADDR_W-1:0]         rt_addr,
  input  logic                      reg_write_enable,
  input  logic [1:0]                reg_input_mux,
  input  logic [THREADS*DATA_W-1:0] alu_out,
  input  logic [THREADS*DATA_W-1:0] lsu_out,
  input  logic [DATA_W-1:0]         immediate,
  input  logic [DATA_W-1:0]         block_id,
  input  logic [DATA_W-1:0]         threads_per_block,
  input  logic [DATA_W-1:0]         thread_base,
  output logic [THREADS*DATA_W-1:0] rs_data,
  output logic [THREADS*DATA_W-1:0] rt_data,
  output logic                      hazard
);

  localparam logic [ADDR_W-1:0] ADDR_BLOCK_IDX = ADDR_W'(NUM_REGS - SPEC_OFS_BLOCK_IDX);
  localparam logic [ADDR_W-1:0] ADDR_BLOCK_DIM = ADDR_W'(NUM_REGS - SPEC_OFS_BLOCK_DIM);

  logic                is_request, is_update, rd_is_gpr, is_load, lane_wr_any;
  logic                rs_special, rt_special;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                hazard_q, hazard_d;

  function automatic logic [DATA_W-1:0] special_value(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] tid
  );
    if (addr == ADDR_BLOCK_IDX)      return block_id;
    else if (addr == ADDR_BLOCK_DIM) return threads_per_block;
    else                             return tid;
  endfunction

  always_comb begin
    is_request  = enable && (core_state == CORE_REQUEST);
    is_update   = enable && (core_state == CORE_UPDATE);
    rd_is_gpr   = rd_addr < ADDR_BLOCK_IDX;
    rs_special  = rs_addr >= ADDR_BLOCK_IDX;
    rt_special  = rt_addr >= ADDR_BLOCK_IDX;
    is_load     = reg_write_enable && (reg_input_mux == REG_MUX_MEM) && rd_is_gpr;
    lane_wr_any = is_update && reg_write_enable && rd_is_gpr &&
                  (reg_input_mux != REG_MUX_RSVD);

    // Hazard samples the scoreboard before this request's own load is recorded
    pending_d = pending_q;
    hazard_d  = hazard_q;
    if (is_request) begin
      hazard_d = pending_q[rs_addr] | pending_q[rt_addr];
      if (is_load) begin
        pending_d[rd_addr] = 1'b1;
      end
    end else if (is_update && is_load) begin
      pending_d[rd_addr] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      hazard_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      hazard_q  <= hazard_d;
    end
  end

  assign hazard = hazard_q;

  for (genvar i = 0; i < THREADS; i++) begin : g_lane
    logic [DATA_W-1:0] tid;
    logic [DATA_W-1:0] lane_wr_data;
    logic [DATA_W-1:0] rs_sval, rt_sval;

    assign tid = thread_base + DATA_W'(i);

    always_comb begin
      rs_sval = special_value(rs_addr, tid);
      rt_sval = special_value(rt_addr, tid);
      case (reg_input_mux)
        REG_MUX_MEM:   lane_wr_data = lsu_out[i*DATA_W +: DATA_W];
        REG_MUX_CONST: lane_wr_data = immediate;
        default:       lane_wr_data = alu_out[i*DATA_W +: DATA_W];
      endcase
    end

    lane_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_bank (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (lane_wr_any && thread_mask[i]),
      .wr_addr        (rd_addr),
      .wr_data        (lane_wr_data),
      .cap_en         (is_request),
      .rs_addr        (rs_addr),
      .rt_addr        (rt_addr),
      .rs_special     (rs_special),
      .rs_special_val (rs_sval),
      .rt_special     (rt_special),
      .rt_special_val (rt_sval),
      .rs_data        (rs_data[i*DATA_W +: DATA_W]),
      .rt_data        (rt_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_register_file.sv
// ============================================================================
// tb_vector_register_file : directed self-checking bench for vector_register_file
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_register_file;
  import gpu_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic [3:0]  thread_mask;
  logic [3:0]  rd_addr, rs_addr, rt_addr;
  logic        reg_write_enable;
  logic [1:0]  reg_input_mux;
  logic [31:0] alu_out, lsu_out;
  logic [7:0]  immediate, block_id, threads_per_block, thread_base;
  logic [31:0] rs_data, rt_data;
  logic        hazard;

  int passed = 0;
  int total  = 0;

  vector_register_file #(.THREADS(4), .DATA_W(8), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .thread_mask(thread_mask), .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .reg_write_enable(reg_write_enable), .reg_input_mux(reg_input_mux),
    .alu_out(alu_out), .lsu_out(lsu_out), .immediate(immediate), .block_id(block_id),
    .threads_per_block(threads_per_block), .thread_base(thread_base),
    .rs_data(rs_data), .rt_data(rt_data), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] rs, input logic [3:0] rt);
    core_state = CORE_REQUEST; rs_addr = rs; rt_addr = rt; reg_write_enable = 1'b0;
    tick();
  endtask

  task automatic update(input logic [3:0] rd, input logic [1:0] mux, input logic [3:0] mask);
    core_state = CORE_UPDATE; rd_addr = rd; reg_input_mux = mux;
    reg_write_enable = 1'b1; thread_mask = mask;
    tick();
    reg_write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = CORE_IDLE; thread_mask = 4'hF;
    rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_write_enable = 1'b0;
    reg_input_mux = REG_MUX_ALU; alu_out = '0; lsu_out = '0; immediate = '0;
    block_id = '0; threads_per_block = '0; thread_base = '0;
    tick(); tick();
    check("reset_rs", rs_data, 32'h0);
    check("reset_rt", rt_data, 32'h0);
    check("reset_hazard", {31'b0, hazard}, 32'h0);
    reset = 1'b0;

    request(4'd1, 4'd2);
    check("req_empty_rs", rs_data, 32'h0);
    check("req_empty_rt", rt_data, 32'h0);
    check("req_empty_hazard", {31'b0, hazard}, 32'h0);

    // Masked CONST write: lane 2 is off
    immediate = 8'hDE;
    update(4'd1, REG_MUX_CONST, 4'b1011);
    request(4'd1, 4'd0);
    check("masked_const_rs", rs_data, 32'hDE00DEDE);

    // Special registers, %threadIdx wraps past 0xFF
    block_id = 8'h01; threads_per_block = 8'h04; thread_base = 8'hFE;
    request(4'd13, 4'd15);
    check("special_blockidx", rs_data, 32'h01010101);
    check("special_threadidx", rt_data, 32'h0100FFFE);

    // Write to a special is dropped
    alu_out = 32'h55555555;
    update(4'd14, REG_MUX_ALU, 4'hF);
    request(4'd14, 4'd13);
    check("special_write_drop", rs_data, 32'h04040404);

    // Per-lane ALU write with mask
    alu_out = 32'h44332211;
    update(4'd2, REG_MUX_ALU, 4'b0110);
    request(4'd0, 4'd2);
    check("alu_lane_slice", rt_data, 32'h00332200);

    // Reserved mux writes nothing
    immediate = 8'hAA; alu_out = 32'h77777777; lsu_out = 32'h66666666;
    update(4'd3, REG_MUX_RSVD, 4'hF);
    request(4'd3, 4'd1);
    check("rsvd_mux_nowrite", rs_data, 32'h0);
    check("rt_r1_retained", rt_data, 32'hDE00DEDE);

    // Load scoreboard
    core_state = CORE_REQUEST; rd_addr = 4'd5; reg_input_mux = REG_MUX_MEM;
    reg_write_enable = 1'b1; rs_addr = 4'd0; rt_addr = 4'd0;
    tick();
    reg_write_enable = 1'b0;
    check("load_req_hazard", {31'b0, hazard}, 32'h0);
    core_state = CORE_WAIT; tick();
    request(4'd5, 4'd0);
    check("raw_hazard", {31'b0, hazard}, 32'h1);
    lsu_out = 32'h3F3E3D3C;
    update(4'd5, REG_MUX_MEM, 4'hF);
    check("hazard_held_in_update", {31'b0, hazard}, 32'h1);
    request(4'd5, 4'd0);
    check("hazard_cleared", {31'b0, hazard}, 32'h0);
    check("load_data", rs_data, 32'h3F3E3D3C);

    // enable low freezes captures
    enable = 1'b0;
    request(4'd1, 4'd2);
    check("enable_low_hold_rs", rs_data, 32'h3F3E3D3C);
    enable = 1'b1;

    // Async reset mid-WAIT with a pending load
    core_state = CORE_REQUEST; rd_addr = 4'd5; reg_input_mux = REG_MUX_MEM;
    reg_write_enable = 1'b1; rs_addr = 4'd0; rt_addr = 4'd0;
    tick();
    request(4'd5, 4'd0);
    check("hazard_before_reset", {31'b0, hazard}, 32'h1);
    core_state = CORE_WAIT;
    tick();
    reset = 1'b1;
    #2;
    check("async_reset_hazard", {31'b0, hazard}, 32'h0);
    check("async_reset_rs", rs_data, 32'h0);
    tick();
    reset = 1'b0;
    request(4'd5, 4'd1);
    check("post_reset_hazard", {31'b0, hazard}, 32'h0);
    check("post_reset_r1", rt_data, 32'h0);

    // enable low in UPDATE: no write, no scoreboard change
    enable = 1'b0; immediate = 8'hAA;
    update(4'd3, REG_MUX_CONST, 4'hF);
    core_state = CORE_REQUEST; rd_addr = 4'd6; reg_input_mux = REG_MUX_MEM;
    reg_write_enable = 1'b1;
    tick();
    enable = 1'b1;
    request(4'd3, 4'd6);
    check("enable_low_nowrite", rs_data, 32'h0);
    check("enable_low_nopending", {31'b0, hazard}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
